memory_h_reader: RTL and testbench
==================================

Name: memory_h_reader

Overview:
- Read-side sequencer for the per-timestep LSTM hidden-state memory, used in the backward (BPTT) pass.
- Walks timesteps in descending order and drives the memory's read address, one timestep per slot of NUM_LSTM words.
- Captures each parallel NUM_LSTM*WIDTH word vector into a local buffer.
- Streams the buffered elements one per beat over a valid/ready interface to the gradient datapath.

Parameters:
WIDTH, 32, bits per hidden-state element
NUM_LSTM, 53, elements per timestep slot (slot stride in memory words)
TIMESTEP, 7, number of real timesteps; memory holds TIMESTEP+1 slots, slot 0 = initial h
STEP_W, 4, width of timestep tag; must hold TIMESTEP
IDX_W, 6, width of element index; must hold NUM_LSTM-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a sweep; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE is exited
done  out  1  one-cycle pulse after the final element is accepted
rd_addr  out  9  memory read address, registered
mem_i  in  NUM_LSTM*WIDTH  combinational memory read vector; element k in bits [k*WIDTH +: WIDTH]
o_data  out  WIDTH  streamed element
o_valid  out  1  o_data and tags valid
o_ready  in  1  downstream accepts the current beat
o_idx  out  IDX_W  element index within the timestep, 0..NUM_LSTM-1
o_step  out  STEP_W  timestep tag of the current beat
o_last_elem  out  1  high on the beat with o_idx == NUM_LSTM-1
o_last  out  1  high on the final beat of the sweep

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output = 0, including rd_addr, o_data, tags and done; buffer contents don't-care. Takes effect immediately, mid-sweep included. o_valid falls without waiting for a handshake. No partial sweep resumes after reset.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE + start=1 at an edge:
  - go to LOAD;
  - set step=TIMESTEP, rd_addr=TIMESTEP*NUM_LSTM, busy=1.
- start is ignored in every state other than IDLE.
- LOAD (exactly one cycle): rd_addr is stable and mem_i is valid; at the edge, capture all of mem_i into the buffer, set idx=0, go to STREAM.
- STREAM:
  - o_valid=1, o_data=buffer[idx], o_idx=idx, o_step=step.
  - While o_valid && !o_ready, o_data and all tags hold stable.
  - On a handshake with idx<NUM_LSTM-1: idx+1.
  - On a handshake with idx==NUM_LSTM-1 and step>last_step: step-1, rd_addr-=NUM_LSTM, go to LOAD.
  - On a handshake with idx==NUM_LSTM-1 and step==last_step: go to DONE.
- o_valid is low in LOAD, giving a 1-cycle bubble per timestep.
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0. rd_addr holds its last value.
- last_step = 1 by default (slot 0 is not read).
- Latency: start accepted at edge k → LOAD in cycle k+1 → first o_valid in cycle k+2.
- Sweep length with o_ready tied high: TIMESTEP*(NUM_LSTM+1) cycles from LOAD to the last beat, then 1 DONE cycle.
- Address arithmetic: subtract NUM_LSTM per step (no multiplier); 9-bit unsigned; no wrap occurs because NUM_LSTM*(TIMESTEP+1) <= 512 is a parameter constraint.
- Buffer isolation: memory writes after capture do not affect streamed data until the next LOAD.
- o_last = o_last_elem && step==last_step.

Optional Feature:
MEMH_RD_H0_EN
- Defined: last_step=0, so slot 0 (initial h) is read and streamed as a final step tagged o_step=0. The sweep has TIMESTEP+1 steps.
- Undefined: last_step=1 and slot 0 is never addressed.

Test Plan:
- Defaults, mem[a]=a, o_ready=1, start pulse:
  - rd_addr=371 in LOAD; first beat o_data=371, o_step=7, o_idx=0;
  - beat 53 o_data=423 with o_last_elem=1; then a 1-cycle bubble with rd_addr=318;
  - final beat o_data=105 with o_last=1 and o_step=1; total 371 beats; done pulses 1 cycle later.
- Backpressure: drop o_ready for 3 cycles on o_idx=10 of step 7 → o_data=381 and tags held; beat order and count unchanged.
- Buffer isolation: overwrite mem[372]=0xDEAD during STREAM of step 7 → streamed o_idx=1 still = 372.
- start pulsed during STREAM and during DONE → ignored; exactly one sweep of 371 beats; done pulses once.
- rst_n low mid-step 5 → o_valid, busy and rd_addr = 0 in the same cycle; a new start restarts at rd_addr=371, step 7.
- With MEMH_RD_H0_EN defined: 424 beats; the last step has o_step=0 and rd_addr=0; the final beat is o_data=52 with o_last=1.

Source files
------------

// File: rtl/memory_h_reader_if.sv
// memory_h_reader_if
//   Bundles the hidden-state memory read port and the element stream of the
//   BPTT h-reader.
//   master (reader side): drives rd_addr and the o_* stream; samples mem_i and o_ready.
//   slave  (env side)   : supplies mem_i and o_ready.
//   Signals:
//     rd_addr      9-bit memory read address
//     mem_i        NUM_LSTM*WIDTH read vector, element k at [k*WIDTH +: WIDTH]
//     o_data       streamed element
//     o_valid      beat valid
//     o_ready      beat accepted downstream
//     o_idx        element index within the timestep
//     o_step       timestep tag
//     o_last_elem  last element of the timestep
//     o_last       last beat of the sweep
interface memory_h_reader_if #(
    parameter int WIDTH    = 32,
    parameter int NUM_LSTM = 53,
    parameter int STEP_W   = 4,
    parameter int IDX_W    = 6,
    parameter int ADDR_W   = 9
);
    logic [ADDR_W-1:0]         rd_addr;
    logic [NUM_LSTM*WIDTH-1:0] mem_i;
    logic [WIDTH-1:0]          o_data;
    logic                      o_valid;
    logic                      o_ready;
    logic [IDX_W-1:0]          o_idx;
    logic [STEP_W-1:0]         o_step;
    logic                      o_last_elem;
    logic                      o_last;

    modport master (
        output rd_addr, o_data, o_valid, o_idx, o_step, o_last_elem, o_last,
        input  mem_i, o_ready
    );

    modport slave (
        input  rd_addr, o_data, o_valid, o_idx, o_step, o_last_elem, o_last,
        output mem_i, o_ready
    );
endinterface

// File: rtl/memory_h_reader.sv
// memory_h_reader
//   Read-side sequencer for the per-timestep LSTM hidden-state memory used by
//   the backward pass. Walks timestep slots from TIMESTEP down to the last
//   step, latches each slot's parallel word vector in one LOAD cycle, then
//   streams the elements one per beat over a valid/ready interface.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     start  begin a sweep (sampled in IDLE only)
//     busy   sweep in progress (LOAD/STREAM/DONE)
//     done   one-cycle pulse after the final beat is accepted
//     bus    memory_h_reader_if.master: rd_addr/mem_i memory port + o_* stream
//   Build option:
//     MEMH_RD_H0_EN  when defined, slot 0 (initial h) is also read and streamed
//                    as a final step tagged 0; otherwise the sweep stops at step 1.
module memory_h_reader #(
    parameter int WIDTH    = 32,
    parameter int NUM_LSTM = 53,
    parameter int TIMESTEP = 7,
    parameter int STEP_W   = 4,
    parameter int IDX_W    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    memory_h_reader_if.master   bus
);
    localparam int ADDR_W = 9;

    // Top slot address and per-step stride; stepping down by subtraction
    // keeps a multiplier out of the address path.
    localparam logic [ADDR_W-1:0] ADDR_TOP    = ADDR_W'(TIMESTEP * NUM_LSTM);
    localparam logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(NUM_LSTM);
    localparam logic [STEP_W-1:0] STEP_TOP    = STEP_W'(TIMESTEP);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_LSTM - 1);

`ifdef MEMH_RD_H0_EN
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(0);
`else
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(1);
`endif

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t                          state_q;
    logic [NUM_LSTM-1:0][WIDTH-1:0]  buf_q;
    logic [IDX_W-1:0]                idx_q;
    logic [STEP_W-1:0]               step_q;
    logic [IDX_W-1:0]                idx_nxt;
    logic                            hs;

    assign hs      = bus.o_valid && bus.o_ready;
    assign idx_nxt = idx_q + 1'b1;

    assign bus.o_idx  = idx_q;
    assign bus.o_step = step_q;

    // Slot snapshot; only LOAD writes it, so later memory writes cannot leak
    // into the elements of the step being streamed. No reset needed: it is
    // always refilled before it is read.
    always_ff @(posedge clk) begin
        if (state_q == LOAD)
            buf_q <= bus.mem_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            idx_q           <= '0;
            step_q          <= '0;
            bus.rd_addr     <= '0;
            bus.o_data      <= '0;
            bus.o_valid     <= 1'b0;
            bus.o_last_elem <= 1'b0;
            bus.o_last      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q     <= LOAD;
                        step_q      <= STEP_TOP;
                        bus.rd_addr <= ADDR_TOP;
                        busy        <= 1'b1;
                    end
                end

                LOAD: begin
                    // Element 0 comes straight from the memory port; the
                    // buffer takes the whole vector on this same edge.
                    state_q         <= STREAM;
                    idx_q           <= '0;
                    bus.o_valid     <= 1'b1;
                    bus.o_data      <= bus.mem_i[WIDTH-1:0];
                    bus.o_last_elem <= (IDX_LAST == '0);
                    bus.o_last      <= (IDX_LAST == '0) && (step_q == LAST_STEP);
                end

                STREAM: begin
                    if (hs) begin
                        if (idx_q != IDX_LAST) begin
                            idx_q           <= idx_nxt;
                            bus.o_data      <= buf_q[idx_nxt];
                            bus.o_last_elem <= (idx_nxt == IDX_LAST);
                            bus.o_last      <= (idx_nxt == IDX_LAST) && (step_q == LAST_STEP);
                        end else begin
                            bus.o_valid     <= 1'b0;
                            bus.o_last_elem <= 1'b0;
                            bus.o_last      <= 1'b0;
                            if (step_q != LAST_STEP) begin
                                step_q      <= step_q - 1'b1;
                                bus.rd_addr <= bus.rd_addr - ADDR_STRIDE;
                                state_q     <= LOAD;
                            end else begin
                                state_q <= DONE;
                                done    <= 1'b1;
                            end
                        end
                    end
                end

                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_h_reader.sv
// tb_memory_h_reader
//   Self-checking bench for memory_h_reader. A word-addressed memory array
//   feeds mem_i; each sweep's expected beat list and slot addresses are built
//   up front from the memory contents and the timestep walk order, then every
//   valid cycle is compared against the head of that list.
//   Honours MEMH_RD_H0_EN the same way as the design.
module tb_memory_h_reader;
    localparam int WIDTH    = 32;
    localparam int NUM_LSTM = 53;
    localparam int TIMESTEP = 7;
    localparam int STEP_W   = 4;
    localparam int IDX_W    = 6;
`ifdef MEMH_RD_H0_EN
    localparam int LAST = 0;
`else
    localparam int LAST = 1;
`endif
    localparam int NSTEP = TIMESTEP - LAST + 1;
    localparam int NBEAT = NSTEP * NUM_LSTM;
    localparam int BW    = WIDTH + IDX_W + STEP_W + 2;

    typedef logic [BW-1:0] beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [WIDTH-1:0] mem [0:511];

    memory_h_reader_if #(.WIDTH(WIDTH), .NUM_LSTM(NUM_LSTM), .STEP_W(STEP_W),
                         .IDX_W(IDX_W), .ADDR_W(9)) bus ();

    memory_h_reader #(.WIDTH(WIDTH), .NUM_LSTM(NUM_LSTM), .TIMESTEP(TIMESTEP),
                      .STEP_W(STEP_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Combinational memory read, refreshed mid-cycle from the registered address.
    always @(negedge clk) begin
        for (int k = 0; k < NUM_LSTM; k++)
            bus.mem_i[k*WIDTH +: WIDTH] = mem[(int'(bus.rd_addr) + k) % 512];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t cur_beat();
        return {bus.o_data, bus.o_idx, bus.o_step, bus.o_last_elem, bus.o_last};
    endfunction

    // mode: 0 ready high, 1 random ready, 2 ready dropped 3 cycles at idx 10 of the top step
    task automatic sweep(input int mode, input bit poke, input bit isolate, input bit rst_mid);
        beat_t q[$];
        int    lq[$];
        int    beats = 0, done_cnt = 0, first_v = -1, last_c = -1, drop = 0;
        bit    fin = 0, aborted = 0, r;

        for (int s = TIMESTEP; s >= LAST; s--) begin
            lq.push_back(s * NUM_LSTM);
            for (int i = 0; i < NUM_LSTM; i++)
                q.push_back({mem[s*NUM_LSTM + i], IDX_W'(i), STEP_W'(s),
                             (i == NUM_LSTM-1), (i == NUM_LSTM-1) && (s == LAST)});
        end

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;

        for (int cyc = 0; cyc < 4000 && !fin && !aborted; cyc++) begin
            if (done) begin
                done_cnt++;
                chk("busy_in_done", 64'(busy), 64'(1));
                chk("done_delay", 64'(cyc), 64'(last_c + 1));
                chk("beats_left_at_done", 64'(q.size()), 64'(0));
                if (poke) start = 1'b1;
            end else if (done_cnt > 0) begin
                chk("busy_after_done", 64'(busy), 64'(0));
                fin = 1;
            end else if (busy && !bus.o_valid) begin
                if (lq.size() == 0) chk("extra_load", 64'(1), 64'(0));
                else chk("load_addr", 64'(bus.rd_addr), 64'(lq.pop_front()));
            end

            if (bus.o_valid) begin
                if (first_v < 0) first_v = cyc;
                if (q.size() == 0) chk("extra_beat", 64'(1), 64'(0));
                else chk("beat", 64'(cur_beat()), 64'(q[0]));

                if (rst_mid && bus.o_step == STEP_W'(5) && bus.o_idx == IDX_W'(3)) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_valid", 64'(bus.o_valid), 64'(0));
                    chk("rst_busy", 64'(busy), 64'(0));
                    chk("rst_addr", 64'(bus.rd_addr), 64'(0));
                    chk("rst_data", 64'({bus.o_data, bus.o_last, done}), 64'(0));
                    aborted = 1;
                end else begin
                    if (isolate && cyc == first_v)
                        mem[TIMESTEP*NUM_LSTM + 1] = 32'hDEAD;
                    case (mode)
                        1:       r = ($urandom_range(0, 3) != 0);
                        2: begin
                            r = 1'b1;
                            if (bus.o_step == STEP_W'(TIMESTEP) && bus.o_idx == IDX_W'(10) && drop < 3) begin
                                r = 1'b0;
                                drop++;
                            end
                        end
                        default: r = 1'b1;
                    endcase
                    bus.o_ready = r;
                    if (r && q.size() > 0) begin
                        void'(q.pop_front());
                        beats++;
                        if (q.size() == 0) last_c = cyc;
                    end
                    if (poke && beats == 20 && r) start = 1'b1;
                end
            end else begin
                bus.o_ready = 1'($urandom_range(0, 1));
            end

            if (!aborted) begin
                @(negedge clk);
                start = 1'b0;
            end
        end

        if (aborted) begin
            @(negedge clk); rst_n = 1'b1;
            @(negedge clk);
        end else begin
            if (!fin) chk("timeout", 64'(0), 64'(1));
            chk("beat_count", 64'(beats), 64'(NBEAT));
            chk("done_pulses", 64'(done_cnt), 64'(1));
            chk("first_valid_latency", 64'(first_v), 64'(1));
            if (mode == 0)
                chk("load_to_last_cycles", 64'(last_c + 1), 64'(NSTEP * (NUM_LSTM + 1)));
            if (mode == 2) chk("drop_cycles", 64'(drop), 64'(3));
        end
    endtask

    initial begin
        bus.o_ready = 1'b0;
        for (int a = 0; a < 512; a++) mem[a] = WIDTH'(a);

        // Reset state
        #12;
        chk("reset_valid", 64'(bus.o_valid), 64'(0));
        chk("reset_busy_done", 64'({busy, done}), 64'(0));
        chk("reset_addr", 64'(bus.rd_addr), 64'(0));
        chk("reset_tags", 64'(cur_beat()), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Identity memory, ready tied high
        sweep(0, 0, 0, 0);

        // Backpressure at idx 10 of the top step, plus a post-capture overwrite
        for (int a = 0; a < 512; a++) mem[a] = WIDTH'(a);
        sweep(2, 0, 1, 0);

        // start pulses during STREAM and DONE are ignored
        for (int a = 0; a < 512; a++) mem[a] = WIDTH'(a);
        sweep(0, 1, 0, 0);
        repeat (3) @(negedge clk);
        chk("no_restart", 64'({busy, bus.o_valid}), 64'(0));

        // Reset mid-step 5, then a clean restart
        sweep(0, 0, 0, 1);
        chk("post_rst_idle", 64'({busy, bus.o_valid}), 64'(0));
        sweep(0, 0, 0, 0);

        // Random contents, random backpressure
        for (int n = 0; n < 2; n++) begin
            for (int a = 0; a < 512; a++) mem[a] = $urandom;
            sweep(1, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
